// File: rtl/mm6532_arb_if.sv
// Request/response and RIOT bus signals for the two-requester MM6532 arbiter.
// The arbiter sits on the slave modport; the requesters and the RIOT model sit on master.
interface mm6532_arb_if;
    logic       R0_REQ;
    logic       R0_WE;
    logic       R0_RAM;
    logic [6:0] R0_A;
    logic [7:0] R0_WD;
    logic       R0_ACK;
    logic [7:0] R0_RD;

    logic       R1_REQ;
    logic       R1_WE;
    logic       R1_RAM;
    logic [6:0] R1_A;
    logic [7:0] R1_WD;
    logic       R1_ACK;
    logic [7:0] R1_RD;

    logic [1:0] RIOT_CS;
    logic       RIOT_RS_N;
    logic       RIOT_R_W;
    logic [6:0] RIOT_A;
    logic [7:0] RIOT_D_IN;
    logic [7:0] RIOT_D_OUT;

    logic       BUSY;

    modport slave (
        input  R0_REQ, R0_WE, R0_RAM, R0_A, R0_WD,
        input  R1_REQ, R1_WE, R1_RAM, R1_A, R1_WD,
        input  RIOT_D_OUT,
        output R0_ACK, R0_RD, R1_ACK, R1_RD,
        output RIOT_CS, RIOT_RS_N, RIOT_R_W, RIOT_A, RIOT_D_IN,
        output BUSY
    );

    modport master (
        output R0_REQ, R0_WE, R0_RAM, R0_A, R0_WD,
        output R1_REQ, R1_WE, R1_RAM, R1_A, R1_WD,
        output RIOT_D_OUT,
        input  R0_ACK, R0_RD, R1_ACK, R1_RD,
        input  RIOT_CS, RIOT_RS_N, RIOT_R_W, RIOT_A, RIOT_D_IN,
        input  BUSY
    );
endinterface

// File: rtl/mm6532_arb.sv
// Two-requester round-robin arbiter for a single MM6532 RIOT bus.
// A grant latches the winner's command straight into the bus registers, which
// then double as the transaction record for the whole ACCESS phase.
module mm6532_arb #(
    parameter int ACCESS_CYCLES = 1   // bus hold time per transaction, 1..4
) (
    input  logic         CLK,
    input  logic         RES,
    mm6532_arb_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [1:0] CNT_LOAD = 2'(ACCESS_CYCLES - 1);

    state_t     state;
    logic [1:0] cnt;
    logic       last_grant;
    logic       owner;
    logic       grant;
    logic       any_req;

    logic       ack0_q, ack1_q;
    logic [7:0] rd0_q, rd1_q;
    logic [1:0] cs_q;
    logic       rs_n_q, r_w_q;
    logic [6:0] a_q;
    logic [7:0] d_in_q;
    logic       busy_q;

    logic       sel_we, sel_ram;
    logic [6:0] sel_a;
    logic [7:0] sel_wd;

    // Round-robin pick: a lone requester always wins, a conflict goes to the one not served last.
    always_comb begin
        any_req = bus.R0_REQ | bus.R1_REQ;
        grant   = 1'b0;
        if (bus.R0_REQ && bus.R1_REQ)
            grant = ~last_grant;
        else if (bus.R1_REQ)
            grant = 1'b1;
        sel_we  = grant ? bus.R1_WE  : bus.R0_WE;
        sel_ram = grant ? bus.R1_RAM : bus.R0_RAM;
        sel_a   = grant ? bus.R1_A   : bus.R0_A;
        sel_wd  = grant ? bus.R1_WD  : bus.R0_WD;
    end

    // Transaction FSM; every output is a register so nothing combinational reaches the RIOT pins.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rd0_q      <= 8'h00;
            rd1_q      <= 8'h00;
            cs_q       <= 2'b00;
            rs_n_q     <= 1'b1;
            r_w_q      <= 1'b1;
            a_q        <= 7'h00;
            d_in_q     <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ACCESS;
                        cnt        <= CNT_LOAD;
                        owner      <= grant;
                        last_grant <= grant;
                        busy_q     <= 1'b1;
                        cs_q       <= 2'b01;
                        rs_n_q     <= ~sel_ram;
                        r_w_q      <= ~sel_we;
                        a_q        <= sel_a;
                        d_in_q     <= sel_wd;
                    end
                end
                ACCESS: begin
                    if (cnt == 2'd0) begin
                        state  <= DONE;
                        cs_q   <= 2'b00;
                        rs_n_q <= 1'b1;
                        r_w_q  <= 1'b1;
                        a_q    <= 7'h00;
                        d_in_q <= 8'h00;
                        if (owner) ack1_q <= 1'b1;
                        else       ack0_q <= 1'b1;
                        // r_w_q still holds the latched direction at this edge
                        if (r_w_q) begin
                            if (owner) rd1_q <= bus.RIOT_D_OUT;
                            else       rd0_q <= bus.RIOT_D_OUT;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.R0_ACK    = ack0_q;
    assign bus.R1_ACK    = ack1_q;
    assign bus.R0_RD     = rd0_q;
    assign bus.R1_RD     = rd1_q;
    assign bus.RIOT_CS   = cs_q;
    assign bus.RIOT_RS_N = rs_n_q;
    assign bus.RIOT_R_W  = r_w_q;
    assign bus.RIOT_A    = a_q;
    assign bus.RIOT_D_IN = d_in_q;
    assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_mm6532_arb.sv
// Directed bench for mm6532_arb: one instance with ACCESS_CYCLES=1 driven from a
// vector table plus hand sequences, and one with ACCESS_CYCLES=3 for the held-bus case.
module tb_mm6532_arb;

    logic CLK;
    logic RES1;
    logic RES3;

    mm6532_arb_if if1 ();
    mm6532_arb_if if3 ();

    mm6532_arb #(.ACCESS_CYCLES(1)) dut1 (.CLK(CLK), .RES(RES1), .bus(if1.slave));
    mm6532_arb #(.ACCESS_CYCLES(3)) dut3 (.CLK(CLK), .RES(RES3), .bus(if3.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One requester command: {REQ, WE, RAM, A[6:0], WD[7:0]}
    typedef logic [17:0] rq_t;
    // Observed outputs: {BUSY, R1_ACK, R0_ACK, CS, RS_N, R_W, A, D_IN, R0_RD, R1_RD}
    typedef logic [37:0] ob_t;

    typedef struct {
        string     name;
        rq_t       r0;
        rq_t       r1;
        logic [7:0] dout;
        ob_t       exp;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic rq_t rq(input logic req, input logic we, input logic ram,
                               input logic [6:0] a, input logic [7:0] wd);
        return {req, we, ram, a, wd};
    endfunction

    function automatic ob_t pk(input logic busy, input logic ack1, input logic ack0,
                               input logic [1:0] cs, input logic rs_n, input logic r_w,
                               input logic [6:0] a, input logic [7:0] d_in,
                               input logic [7:0] rd0, input logic [7:0] rd1);
        return {busy, ack1, ack0, cs, rs_n, r_w, a, d_in, rd0, rd1};
    endfunction

    function automatic vec_t mkv(input string name, input rq_t r0, input rq_t r1,
                                 input logic [7:0] dout, input ob_t exp);
        vec_t v;
        v.name = name; v.r0 = r0; v.r1 = r1; v.dout = dout; v.exp = exp;
        return v;
    endfunction

    function automatic ob_t snap1();
        return {if1.BUSY, if1.R1_ACK, if1.R0_ACK, if1.RIOT_CS, if1.RIOT_RS_N, if1.RIOT_R_W,
                if1.RIOT_A, if1.RIOT_D_IN, if1.R0_RD, if1.R1_RD};
    endfunction

    function automatic ob_t snap3();
        return {if3.BUSY, if3.R1_ACK, if3.R0_ACK, if3.RIOT_CS, if3.RIOT_RS_N, if3.RIOT_R_W,
                if3.RIOT_A, if3.RIOT_D_IN, if3.R0_RD, if3.R1_RD};
    endfunction

    task automatic drive1(input rq_t r0, input rq_t r1, input logic [7:0] dout);
        {if1.R0_REQ, if1.R0_WE, if1.R0_RAM, if1.R0_A, if1.R0_WD} = r0;
        {if1.R1_REQ, if1.R1_WE, if1.R1_RAM, if1.R1_A, if1.R1_WD} = r1;
        if1.RIOT_D_OUT = dout;
    endtask

    task automatic drive3(input rq_t r0, input rq_t r1, input logic [7:0] dout);
        {if3.R0_REQ, if3.R0_WE, if3.R0_RAM, if3.R0_A, if3.R0_WD} = r0;
        {if3.R1_REQ, if3.R1_WE, if3.R1_RAM, if3.R1_A, if3.R1_WD} = r1;
        if3.RIOT_D_OUT = dout;
    endtask

    task automatic chk(input string name, input ob_t act, input ob_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (busy,ack1,ack0,cs,rs_n,r_w,a,d_in,rd0,rd1)",
                     name, act, exp);
        end
    endtask

    vec_t vt[$];
    rq_t  nr;
    rq_t  b0, b1;
    ob_t  idle0;

    initial begin
        nr    = rq(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
        idle0 = pk(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 7'h00, 8'h00, 8'h00, 8'h00);
        b0    = rq(1'b1, 1'b1, 1'b1, 7'h22, 8'hA5);
        b1    = rq(1'b1, 1'b0, 1'b0, 7'h33, 8'h0F);

        // I/O write from R0, single ACCESS cycle
        vt.push_back(mkv("035_access", rq(1,1,0,7'h01,8'hFF), nr, 8'h00,
                         pk(1,0,0,2'b01,1,0,7'h01,8'hFF,8'h00,8'h00)));
        vt.push_back(mkv("035_ack",    rq(1,1,0,7'h01,8'hFF), nr, 8'h00,
                         pk(1,0,1,2'b00,1,1,7'h00,8'h00,8'h00,8'h00)));
        vt.push_back(mkv("035_idle",   nr, nr, 8'h00, idle0));
        // R1 RAM write then read back
        vt.push_back(mkv("036_wr_access", nr, rq(1,1,1,7'h10,8'h5A), 8'h00,
                         pk(1,0,0,2'b01,0,0,7'h10,8'h5A,8'h00,8'h00)));
        vt.push_back(mkv("036_wr_ack",    nr, rq(1,1,1,7'h10,8'h5A), 8'hEE,
                         pk(1,1,0,2'b00,1,1,7'h00,8'h00,8'h00,8'h00)));
        vt.push_back(mkv("036_rd_done",   nr, rq(1,0,1,7'h10,8'h33), 8'h00,
                         pk(0,0,0,2'b00,1,1,7'h00,8'h00,8'h00,8'h00)));
        vt.push_back(mkv("036_rd_access", nr, rq(1,0,1,7'h10,8'h33), 8'h00,
                         pk(1,0,0,2'b01,0,1,7'h10,8'h33,8'h00,8'h00)));
        vt.push_back(mkv("036_rd_ack",    nr, rq(1,0,1,7'h10,8'h33), 8'h5A,
                         pk(1,1,0,2'b00,1,1,7'h00,8'h00,8'h00,8'h5A)));
        vt.push_back(mkv("036_idle",      nr, nr, 8'h00,
                         pk(0,0,0,2'b00,1,1,7'h00,8'h00,8'h00,8'h5A)));
        // Both held: R0, R1, R0, R1 with one IDLE gap between transactions
        vt.push_back(mkv("037_g0a_access", b0, b1, 8'hC3, pk(1,0,0,2'b01,0,0,7'h22,8'hA5,8'h00,8'h5A)));
        vt.push_back(mkv("037_g0a_ack",    b0, b1, 8'hC3, pk(1,0,1,2'b00,1,1,7'h00,8'h00,8'h00,8'h5A)));
        vt.push_back(mkv("037_gap1",       b0, b1, 8'hC3, pk(0,0,0,2'b00,1,1,7'h00,8'h00,8'h00,8'h5A)));
        vt.push_back(mkv("037_g1a_access", b0, b1, 8'hC3, pk(1,0,0,2'b01,1,1,7'h33,8'h0F,8'h00,8'h5A)));
        vt.push_back(mkv("037_g1a_ack",    b0, b1, 8'hC3, pk(1,1,0,2'b00,1,1,7'h00,8'h00,8'h00,8'hC3)));
        vt.push_back(mkv("037_gap2",       b0, b1, 8'hC3, pk(0,0,0,2'b00,1,1,7'h00,8'h00,8'h00,8'hC3)));
        vt.push_back(mkv("037_g0b_access", b0, b1, 8'hC3, pk(1,0,0,2'b01,0,0,7'h22,8'hA5,8'h00,8'hC3)));
        vt.push_back(mkv("037_g0b_ack",    b0, b1, 8'hC3, pk(1,0,1,2'b00,1,1,7'h00,8'h00,8'h00,8'hC3)));
        vt.push_back(mkv("037_gap3",       b0, b1, 8'hC3, pk(0,0,0,2'b00,1,1,7'h00,8'h00,8'h00,8'hC3)));
        vt.push_back(mkv("037_g1b_access", b0, b1, 8'hC3, pk(1,0,0,2'b01,1,1,7'h33,8'h0F,8'h00,8'hC3)));
        vt.push_back(mkv("037_g1b_ack",    b0, b1, 8'h3C, pk(1,1,0,2'b00,1,1,7'h00,8'h00,8'h00,8'h3C)));
        vt.push_back(mkv("037_idle",       nr, nr, 8'h00, pk(0,0,0,2'b00,1,1,7'h00,8'h00,8'h00,8'h3C)));

        // Reset state of both instances
        RES1 = 1'b1;
        RES3 = 1'b1;
        drive1(nr, nr, 8'h00);
        drive3(nr, nr, 8'h00);
        repeat (2) @(posedge CLK);
        #1;
        chk("032_reset_ac1", snap1(), idle0);
        chk("032_reset_ac3", snap3(), idle0);

        @(negedge CLK);
        RES1 = 1'b0;
        RES3 = 1'b0;

        // Table-driven run on the single-cycle instance
        foreach (vt[i]) begin
            @(negedge CLK);
            drive1(vt[i].r0, vt[i].r1, vt[i].dout);
            @(posedge CLK);
            #1;
            chk(vt[i].name, snap1(), vt[i].exp);
        end

        // Reset in the middle of an R1 write, then re-grant of the held request
        @(negedge CLK);
        drive1(nr, rq(1,1,1,7'h44,8'h77), 8'h00);
        @(posedge CLK);
        #1;
        chk("039_access", snap1(), pk(1,0,0,2'b01,0,0,7'h44,8'h77,8'h00,8'h3C));
        #2;
        RES1 = 1'b1;
        #1;
        chk("039_async_rst", snap1(), idle0);
        @(posedge CLK);
        #1;
        chk("039_no_ack", snap1(), idle0);
        @(negedge CLK);
        RES1 = 1'b0;
        @(posedge CLK);
        #1;
        chk("039_regrant", snap1(), pk(1,0,0,2'b01,0,0,7'h44,8'h77,8'h00,8'h00));
        @(posedge CLK);
        #1;
        chk("039_ack", snap1(), pk(1,1,0,2'b00,1,1,7'h00,8'h00,8'h00,8'h00));
        @(negedge CLK);
        drive1(nr, nr, 8'h00);
        @(posedge CLK);
        #1;
        chk("039_idle", snap1(), idle0);

        // R0 served last, then reset: the first conflict must still go to R0
        @(negedge CLK);
        drive1(rq(1,1,0,7'h01,8'h11), nr, 8'h00);
        @(posedge CLK);
        #1;
        chk("026_r0_access", snap1(), pk(1,0,0,2'b01,1,0,7'h01,8'h11,8'h00,8'h00));
        @(negedge CLK);
        drive1(nr, nr, 8'h00);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RES1 = 1'b1;
        @(negedge CLK);
        RES1 = 1'b0;
        drive1(rq(1,0,0,7'h02,8'h00), rq(1,0,0,7'h03,8'h00), 8'h00);
        @(posedge CLK);
        #1;
        chk("032_first_conflict", snap1(), pk(1,0,0,2'b01,1,1,7'h02,8'h00,8'h00,8'h00));
        @(posedge CLK);
        #1;
        chk("032_conflict_ack", snap1(), pk(1,0,1,2'b00,1,1,7'h00,8'h00,8'h00,8'h00));
        @(negedge CLK);
        drive1(nr, nr, 8'h00);

        // ACCESS_CYCLES=3: R0 read; address changes and REQ drops during the 2nd cycle
        @(negedge CLK);
        drive3(rq(1,0,0,7'h05,8'h00), nr, 8'h9E);
        @(posedge CLK);
        #1;
        chk("038_cycle1", snap3(), pk(1,0,0,2'b01,1,1,7'h05,8'h00,8'h00,8'h00));
        @(posedge CLK);
        #1;
        chk("038_cycle2", snap3(), pk(1,0,0,2'b01,1,1,7'h05,8'h00,8'h00,8'h00));
        @(negedge CLK);
        drive3(rq(0,1,1,7'h7F,8'hAA), nr, 8'h9E);
        @(posedge CLK);
        #1;
        chk("038_cycle3", snap3(), pk(1,0,0,2'b01,1,1,7'h05,8'h00,8'h00,8'h00));
        @(posedge CLK);
        #1;
        chk("038_ack", snap3(), pk(1,0,1,2'b00,1,1,7'h00,8'h00,8'h9E,8'h00));
        @(posedge CLK);
        #1;
        chk("038_idle", snap3(), pk(0,0,0,2'b00,1,1,7'h00,8'h00,8'h9E,8'h00));
        @(posedge CLK);
        #1;
        chk("038_no_restart", snap3(), pk(0,0,0,2'b00,1,1,7'h00,8'h00,8'h9E,8'h00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
